registered_mux_n: RTL

Parametrised, registered N-to-1 data selector with a valid/ready handshake and a two-entry skid buffer. It replaces fixed-width combinational 3-to-1 selection wherever selection must be pipelined, for example in writeback or forwarding paths that stall. The block selects one of `NInputs` words, flags out-of-range selectors, and presents the result one cycle later. It sustains full throughput under back-pressure.

---
 rtl/registered_mux_n.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/registered_mux_n.sv
`default_nettype none
// ============================================================================
//  Module   : registered_mux_n
//  Purpose  : Registered N-to-1 word selector with a valid/ready handshake
//             and a two-entry skid buffer (main + skid). It selects one of
//             NInputs words and flags out-of-range selectors. The result is
//             presented one cycle after acceptance. Full throughput is
//             sustained under back-pressure.
//  Ports    : clk        - clock, all state updates on rising edge
//             reset      - synchronous, active-high reset
//             Selector   - input index, sampled with In_Valid
//             MUX_Data   - flattened inputs, input k at [k*NBits +: NBits]
//             In_Valid   - upstream valid
//             In_Ready   - block can accept (registered)
//             Out_Valid  - MUX_Output / Sel_Error hold a valid result
//             Out_Ready  - downstream accepts
//             MUX_Output - selected word
//             Sel_Error  - result came from Selector >= NInputs
//  Options  : REGISTERED_MUX_HOLD_LAST_EN - when defined, an out-of-range
//             selection forwards the last accepted in-range word instead
//             of zero.
//  Revision : 1.0 - initial release
// ============================================================================
module registered_mux_n #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = (NInputs > 2) ? $clog2(NInputs) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SelBits-1:0]         Selector,
    input  logic [NInputs*NBits-1:0]   MUX_Data,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [NBits-1:0]           MUX_Output,
    output logic                       Sel_Error
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    logic [NBits-1:0]   r_main_word;
    logic               r_main_err;
    logic [NBits-1:0]   r_skid_word;
    logic               r_skid_err;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [NBits-1:0]   w_sel_word;
    logic               w_in_range;
    logic [NBits-1:0]   w_oor_word;
    logic [NBits-1:0]   w_entry_word;
    logic               w_entry_err;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // Widen by one bit so the range check never degenerates into a
    // comparison against a value the selector cannot represent.
    assign w_in_range = ({1'b0, Selector} < (SelBits+1)'(NInputs));

    // Explicit compare-and-pick avoids indexing past the flattened bus
    // when the selector is out of range.
    always_comb begin
        w_sel_word = '0;
        for (int k = 0; k < NInputs; k++) begin
            if (Selector == SelBits'(k)) begin
                w_sel_word = MUX_Data[k*NBits +: NBits];
            end
        end
    end

`ifdef REGISTERED_MUX_HOLD_LAST_EN
    // Last accepted in-range word. An out-of-range entry formed on the same
    // edge as an update sees the value from before that edge.
    logic [NBits-1:0]   r_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_in_xfer && w_in_range) begin
            r_hold <= w_sel_word;
        end
    end

    assign w_oor_word = r_hold;
`else
    assign w_oor_word = '0;
`endif

    assign w_entry_word = w_in_range ? w_sel_word : w_oor_word;
    assign w_entry_err  = ~w_in_range;

    assign w_in_xfer  = In_Valid  & r_in_ready;
    assign w_out_xfer = r_out_valid & Out_Ready;

    // Handshake flags are registered together with the state so In_Ready
    // never depends combinationally on Out_Ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_word <= '0;
            r_main_err  <= 1'b0;
            r_skid_word <= '0;
            r_skid_err  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_word <= w_entry_word;
                        r_main_err  <= w_entry_err;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main_word <= w_entry_word;
                        r_main_err  <= w_entry_err;
                    end else if (w_in_xfer) begin
                        // Downstream stalled: absorb this word into skid
                        // and stop accepting from the next cycle.
                        r_skid_word <= w_entry_word;
                        r_skid_err  <= w_entry_err;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_out_xfer) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_main_word <= r_skid_word;
                        r_main_err  <= r_skid_err;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign In_Ready   = r_in_ready;
    assign Out_Valid  = r_out_valid;
    assign MUX_Output = r_main_word;
    assign Sel_Error  = r_main_err;

endmodule
`default_nettype wire
